conv_window_accumulator: RTL and testbench
==========================================

# conv_window_accumulator

Downstream stage of the 3-tap product multiplexer in the convolution datapath. It sequences the multiplier's `sel` input through the three tap pairs for each kernel row and accumulates the returned 16-bit products into a signed, bias-initialised sum. After the last row it applies ReLU, requantises by right shift, and saturates to 8 bits. The result is presented on a valid/ready output port.

## Interface
- `ROWS`, default 3: kernel rows per output; each row is 3 products. Legal range 1..15.
- `PLAT`, default 1: multiplier latency, i.e. edges from a `sel` value becoming visible to its product becoming visible on `product`. Legal range 1..3.
- `SHIFT`, default 8: requantisation right-shift amount.
- `ACC_W`, default 24: accumulator width, signed.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a window; sampled only in IDLE.
- `bias` in 16: signed; sampled together with an accepted `start`.
- `sel` out 2: to the multiplier. 00 means idle; 01, 10, 11 select tap 0, 1, 2. Registered.
- `product` in 16: unsigned product from the multiplier.
- `busy` out 1: high from the accepted `start` through the output handshake.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 8: unsigned result.
- `ovf` out 1: the current result was clamped high; qualified by `out_valid`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FINAL, HOLD.
- **IDLE**
  - `sel`=00, `busy`=0.
  - When `start`=1 is sampled: `acc` <= sign-extended `bias`, row counter <= 0, `sel` <= 01, `busy` <= 1, go to ISSUE.
- **ISSUE**
  - `sel` steps 01→10→11 on successive cycles.
  - After 11, the row counter increments and `sel` returns to 01.
  - When `sel`=11 and row=ROWS-1: `sel` <= 00, go to DRAIN.
- **Tap tracking**
  - A PLAT-deep shift register carries the bit (`sel`≠00).
  - On each edge where its output is 1: `acc` <= `acc` + zero-extended `product`.
  - Exactly 3·ROWS additions occur per window.
- **DRAIN**
  - Lasts PLAT cycles, so every in-flight product is added.
  - Then go to FINAL.
- **FINAL** (one cycle)
  - If `acc` < 0: `out_data` <= 0, `ovf` <= 0.
  - Otherwise, with t = `acc` >>> SHIFT (truncating):
    - t > 255: `out_data` <= 255, `ovf` <= 1.
    - else `out_data` <= t[7:0], `ovf` <= 0.
  - `out_valid` <= 1, go to HOLD.
- **HOLD**
  - `out_data`, `ovf` and `out_valid` are held stable.
  - `start` is ignored.
  - On `out_valid`&`out_ready`: `out_valid` <= 0, `busy` <= 0, go to IDLE.
  - A new `start` is accepted from the next cycle onward.
- **Width**: 3·15·65025 + 32767 < 2^23, so `acc` never wraps at ACC_W=24.
- **Reset**
  - Asserting `rst` (async) forces IDLE.
  - Reset values: `sel`=00, `busy`=0, `out_valid`=0, `out_data`=0, `ovf`=0, `acc`=0, counters=0, tap shift register cleared.
  - A window in progress is abandoned. No partial sum survives reset.

## Timing
- Let N = 3·ROWS, and let edge 1 be the edge that samples `start`.
- `sel` is non-zero after edges 1..N and returns to 00 after edge N+1.
- Last accumulation occurs at edge N+1+PLAT.
- `out_valid` rises after edge N+2+PLAT. With defaults this is edge 12, i.e. 11 cycles after edge 1.
- Earliest new `start` is sampled on the edge after the handshake edge.
- Throughput with `out_ready` held at 1: one result per N+PLAT+3 cycles.
- `start`=1 while `busy`=1 has no effect in any state.

## Test plan
All scenarios use a bench multiplier model with registered output, PLAT=1, and default parameters.
- **Nominal**: every product = 256, `bias`=0.
  - `acc`=2304, `out_data`=9, `ovf`=0.
  - `out_valid` rises after edge 12.
  - `sel` sequence is 01,10,11 ×3, then 00.
- **Negative bias**: products = 100, `bias`=-32768.
  - `out_data`=0, `ovf`=0.
- **Saturation**: products = 65025, `bias`=0.
  - `acc`=585225, t=2286.
  - `out_data`=255, `ovf`=1.
- **Backpressure**: `out_ready`=0 for 5 cycles after `out_valid`, with `start` pulsed during HOLD.
  - `out_data`, `ovf` and `out_valid` stay stable.
  - `busy`=1 throughout; the `start` pulses are ignored.
  - On `out_ready`=1, the handshake completes and `busy`=0 on the next cycle.
  - A following `start` is accepted.
- **Reset mid-window**: assert `rst` asynchronously while `sel`=10 in row 1.
  - `sel`=00, `busy`=0 and `out_valid`=0 immediately.
  - The next window (products 256, `bias`=0) yields `out_data`=9.
- **Bias-only edge case**: products = 0, `bias`=511.
  - `out_data`=1 (511>>8), `ovf`=0.

Source files
------------

// File: rtl/conv_window_accumulator.sv
// conv_window_accumulator
//   Drives the 3-tap product multiplexer select through every tap of every
//   kernel row, accumulates the returned unsigned products on top of a signed
//   bias, then applies ReLU, right-shift requantisation and 8-bit saturation.
//   The result is offered on a valid/ready port and held until accepted.
//
// Ports
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-high reset
//   start      : begin a window (sampled only while idle)
//   bias[15:0] : signed initial accumulator value, sampled with start
//   sel[1:0]   : multiplier tap select, 00 idle, 01/10/11 = tap 0/1/2
//   product    : unsigned product returned PLAT edges after sel
//   busy       : window in progress, up to and including the output handshake
//   out_valid  : result available
//   out_ready  : consumer accepts the result
//   out_data   : requantised, saturated result
//   ovf        : result was clamped high (qualified by out_valid)
module conv_window_accumulator #(
  parameter int unsigned ROWS  = 3,
  parameter int unsigned PLAT  = 1,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bias,
  output logic [1:0]  sel,
  input  logic [15:0] product,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINAL,
    S_HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              sel_q, sel_d;
  logic [3:0]              row_q, row_d;
  logic [1:0]              drain_q, drain_d;
  logic [PLAT-1:0]         tap_q, tap_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] shifted;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              data_q, data_d;

  assign shifted = acc_q >>> SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    row_d   = row_q;
    drain_d = drain_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    data_d  = data_q;

    // Tap tracker: a 1 enters when a non-idle select is on the bus and leaves
    // PLAT edges later, exactly when that select's product is on `product`.
    tap_d = PLAT'({tap_q, (sel_q != 2'b00)});

    acc_d = acc_q;
    if (tap_q[PLAT-1]) begin
      acc_d = acc_q + $signed({{(ACC_W-16){1'b0}}, product});
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = {{(ACC_W-16){bias[15]}}, bias};
          row_d   = '0;
          sel_d   = 2'b01;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sel_q == 2'b11) begin
          if (row_q == 4'(ROWS - 1)) begin
            sel_d   = '0;
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            row_d = row_q + 4'd1;
            sel_d = 2'b01;
          end
        end else begin
          sel_d = sel_q + 2'b01;
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'(PLAT - 1)) begin
          drain_d = '0;
          state_d = S_FINAL;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_FINAL: begin
        if (acc_q[ACC_W-1]) begin
          data_d = '0;
          ovf_d  = 1'b0;
        end else if (|shifted[ACC_W-1:8]) begin
          data_d = '1;
          ovf_d  = 1'b1;
        end else begin
          data_d = shifted[7:0];
          ovf_d  = 1'b0;
        end
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_conv_window_accumulator.sv
module tb_conv_window_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic [1:0]  sel;
  logic [15:0] product;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  localparam int N = 9;

  always #5 clk = ~clk;

  conv_window_accumulator #(
    .ROWS (3),
    .PLAT (1),
    .SHIFT(8),
    .ACC_W(24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias     (bias),
    .sel      (sel),
    .product  (product),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .ovf      (ovf)
  );

  // Multiplier model: registered, one edge of latency. The n-th non-idle
  // select of a window returns ptab[n]; idle selects return garbage that
  // must never be accumulated.
  logic [15:0] ptab [0:15];
  logic        mclr;
  int          mcnt = 0;
  logic [1:0]  trace [0:63];

  always @(posedge clk) begin
    if (sel != 2'b00) product <= ptab[mcnt % 16];
    else              product <= 16'($urandom);
    if (mclr)              mcnt <= 0;
    else if (sel != 2'b00) mcnt <= mcnt + 1;
  end

  // Reference: bias + sum of the window's products, ReLU, >>8, clamp to 255.
  function automatic logic [8:0] ref_out(input logic [15:0] b);
    int a;
    int t;
    a = int'($signed(b));
    for (int k = 0; k < N; k++) a += int'(ptab[k]);
    if (a < 0) return 9'd0;
    t = a / 256;
    if (t > 255) return {1'b1, 8'd255};
    return {1'b0, t[7:0]};
  endfunction

  task automatic fill(input int v);
    for (int k = 0; k < 16; k++) ptab[k] = 16'(v);
  endtask

  task automatic launch(input logic [15:0] b);
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    mclr  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mclr  = 1'b0;
    bias  = 16'($urandom);
  endtask

  // Returns the edge index (edge 1 = start sample) after which out_valid
  // was first seen, or -1 on timeout; records sel after each edge.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      trace[c] = sel;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic handshake;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (sel !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b expected 00", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_nominal;
    int lat;
    logic [1:0] e;
    fill(256);
    launch(16'd0);
    wait_valid(lat);
    checks++; if (lat !== 12) begin errors++; $display("FAIL nominal_latency: got %0d expected 12", lat); end
    for (int c = 1; c <= N + 1; c++) begin
      e = (c <= N) ? 2'((c - 1) % 3 + 1) : 2'b00;
      checks++;
      if (trace[c] !== e) begin errors++; $display("FAIL nominal_sel[%0d]: got %b expected %b", c, trace[c], e); end
    end
    checks++; if (mcnt !== N) begin errors++; $display("FAIL nominal_issue_count: got %0d expected %0d", mcnt, N); end
    checks++; if (out_data !== 8'd9) begin errors++; $display("FAIL nominal_data: got %0d expected 9", out_data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL nominal_ovf: got %b expected 0", ovf); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nominal_busy_hold: got %b expected 1", busy); end
    handshake();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_fixed(input string name, input int p, input logic [15:0] b,
                            input logic [7:0] ed, input logic eo);
    int lat;
    fill(p);
    launch(b);
    wait_valid(lat);
    checks++; if (lat !== 12) begin errors++; $display("FAIL %s_latency: got %0d expected 12", name, lat); end
    checks++; if (out_data !== ed) begin errors++; $display("FAIL %s_data: got %0d expected %0d", name, out_data, ed); end
    checks++; if (ovf !== eo) begin errors++; $display("FAIL %s_ovf: got %b expected %b", name, ovf, eo); end
    handshake();
  endtask

  task automatic test_backpressure;
    int lat;
    logic [8:0] exp;
    logic [15:0] b;
    for (int k = 0; k < 16; k++) ptab[k] = 16'($urandom_range(0, 3000));
    b = 16'($urandom_range(0, 4000));
    exp = ref_out(b);
    launch(b);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_data !== exp[7:0]) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, out_data, exp[7:0]); end
      checks++; if (ovf !== exp[8]) begin errors++; $display("FAIL bp_ovf[%0d]: got %b expected %b", i, ovf, exp[8]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b expected 1", i, busy); end
      start = (i % 2 == 0);
      bias  = 16'h8000;
    end
    @(negedge clk);
    start = 1'b0;
    handshake();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_after: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b expected 0", out_valid); end
    b = 16'($urandom_range(0, 4000));
    exp = ref_out(b);
    launch(b);
    wait_valid(lat);
    checks++; if (lat !== 12) begin errors++; $display("FAIL bp_next_latency: got %0d expected 12", lat); end
    checks++; if (out_data !== exp[7:0]) begin errors++; $display("FAIL bp_next_data: got %0d expected %0d", out_data, exp[7:0]); end
    handshake();
  endtask

  task automatic test_reset_mid;
    int lat;
    fill(256);
    launch(16'd0);
    for (int c = 1; c <= 5; c++) @(negedge clk);
    checks++; if (sel !== 2'b10) begin errors++; $display("FAIL rstmid_pre_sel: got %b expected 10", sel); end
    rst = 1'b1;
    #1;
    checks++; if (sel !== 2'b00) begin errors++; $display("FAIL rstmid_sel: got %b expected 00", sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    launch(16'd0);
    wait_valid(lat);
    checks++; if (lat !== 12) begin errors++; $display("FAIL rstmid_latency: got %0d expected 12", lat); end
    checks++; if (out_data !== 8'd9) begin errors++; $display("FAIL rstmid_data: got %0d expected 9", out_data); end
    handshake();
  endtask

  task automatic test_random;
    int lat;
    logic [8:0] exp;
    logic [15:0] b;
    for (int w = 0; w < 20; w++) begin
      for (int k = 0; k < 16; k++)
        ptab[k] = (w % 2 == 0) ? 16'($urandom_range(0, 2500)) : 16'($urandom_range(0, 65025));
      b = 16'($urandom);
      exp = ref_out(b);
      launch(b);
      wait_valid(lat);
      checks++; if (lat !== 12) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 12", w, lat); end
      checks++; if (out_data !== exp[7:0]) begin errors++; $display("FAIL rand%0d_data: got %0d expected %0d", w, out_data, exp[7:0]); end
      checks++; if (ovf !== exp[8]) begin errors++; $display("FAIL rand%0d_ovf: got %b expected %b", w, ovf, exp[8]); end
      handshake();
    end
  endtask

  task automatic test_back_to_back;
    int rise[$];
    fill(256);
    @(negedge clk);
    out_ready = 1'b1;
    start     = 1'b1;
    bias      = 16'd0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (out_valid) begin
        rise.push_back(c);
        checks++; if (out_data !== 8'd9) begin errors++; $display("FAIL b2b_data@%0d: got %0d expected 9", c, out_data); end
      end
    end
    start = 1'b0;
    checks++;
    if (rise.size() < 3) begin
      errors++; $display("FAIL b2b_results: got %0d expected >=3", rise.size());
    end else begin
      checks++; if (rise[1] - rise[0] !== 13) begin errors++; $display("FAIL b2b_period0: got %0d expected 13", rise[1] - rise[0]); end
      checks++; if (rise[2] - rise[1] !== 13) begin errors++; $display("FAIL b2b_period1: got %0d expected 13", rise[2] - rise[1]); end
    end
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain_busy: got %b expected 0", busy); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bias = '0;
    out_ready = 1'b0;
    mclr = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_nominal();
    test_fixed("negbias", 100, 16'h8000, 8'd0, 1'b0);
    test_fixed("saturate", 65025, 16'd0, 8'd255, 1'b1);
    test_backpressure();
    test_reset_mid();
    test_fixed("biasonly", 0, 16'd511, 8'd1, 1'b0);
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
